// File: rtl/calc_pkg.sv
// Shared calculator datapath types and constants.
package calc_pkg;
  typedef enum logic [1:0] {IDLE, ADD, NEG, DONE} sm_add_state_t;
  localparam logic SIGN_POS = 1'b1;
endpackage

// File: rtl/serial_fa.sv
// One-bit full adder with a registered carry; clr preloads the carry for a new pass.
module serial_fa (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cin_init,
  input  logic a,
  input  logic b,
  output logic s,
  output logic cout
);
  logic c_q;

  assign s    = a ^ b ^ c_q;
  assign cout = (a & b) | (c_q & (a ^ b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   c_q <= 1'b0;
    else if (clr) c_q <= cin_init;
    else          c_q <= cout;
  end
endmodule

// File: rtl/sm_serial_adder.sv
// Bit-serial sign-magnitude adder: one LSB-first pass of |A| +/- |B|, plus an
// optional two's-complement negate pass when |A| < |B| on differing signs.
module sm_serial_adder
  import calc_pkg::*;
#(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Width-1:0] a_mag,
  input  logic             a_pos,
  input  logic [Width-1:0] b_mag,
  input  logic             b_pos,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] sum_mag,
  output logic             sum_pos,
  output logic             overflow
);
  localparam int CW = $clog2(Width) + 1;

  sm_add_state_t    state_q, state_d;
  logic [Width-1:0] a_sh, b_sh, r_sh, r_next;
  logic [CW-1:0]    cnt;
  logic             diff_q, a_pos_q, b_pos_q;
  logic             accept, last, finish;
  logic             fa_a, fa_b, fa_s, fa_cout, fa_clr, fa_cin;

  assign accept = (state_q == IDLE) && start;
  assign last   = (cnt == CW'(Width - 1));
  assign busy   = (state_q == ADD) || (state_q == NEG);
  assign done   = (state_q == DONE);
  assign r_next = {fa_s, r_sh[Width-1:1]};
  assign finish = (state_d == DONE) && (state_q != DONE);

  // Carry is reloaded at the end of ADD too, seeding the +1 of the negate pass.
  assign fa_clr = accept || ((state_q == ADD) && last);
  assign fa_cin = accept ? (a_pos != b_pos) : 1'b1;

  always_comb begin
    fa_a = a_sh[0];
    fa_b = b_sh[0] ^ diff_q;
    if (state_q == NEG) begin
      fa_a = ~r_sh[0];
      fa_b = 1'b0;
    end
  end

  serial_fa u_fa (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (fa_clr),
    .cin_init (fa_cin),
    .a        (fa_a),
    .b        (fa_b),
    .s        (fa_s),
    .cout     (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last)  state_d = (diff_q && !fa_cout) ? NEG : DONE;
      NEG:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      cnt      <= '0;
      diff_q   <= 1'b0;
      a_pos_q  <= 1'b0;
      b_pos_q  <= 1'b0;
      sum_mag  <= '0;
      sum_pos  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        a_sh    <= a_mag;
        b_sh    <= b_mag;
        r_sh    <= '0;
        cnt     <= '0;
        diff_q  <= (a_pos != b_pos);
        a_pos_q <= a_pos;
        b_pos_q <= b_pos;
      end else if (busy) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r_sh <= r_next;
        cnt  <= last ? '0 : cnt + CW'(1);
      end
      if (finish) begin
        sum_mag  <= r_next;
        // A zero magnitude is always reported as non-negative.
        sum_pos  <= (r_next == '0)      ? SIGN_POS :
                    (state_q == NEG)    ? b_pos_q  : a_pos_q;
        overflow <= (state_q == ADD) && !diff_q && fa_cout;
      end
    end
  end
endmodule

// File: tb/tb_sm_serial_adder.sv
// Directed bench for sm_serial_adder at Width=4 with hand-computed results.
module tb_sm_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a_mag = '0, b_mag = '0;
  logic       a_pos = 1'b0, b_pos = 1'b0;
  logic       busy, done, sum_pos, overflow;
  logic [3:0] sum_mag;
  int         n_tests = 0, n_fail = 0;

  sm_serial_adder #(.Width(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_mag(a_mag), .a_pos(a_pos), .b_mag(b_mag), .b_pos(b_pos),
    .busy(busy), .done(done), .sum_mag(sum_mag), .sum_pos(sum_pos),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Start in cycle N, watch 16 cycles; record first done cycle and done count.
  task automatic run_op(input string tag, input logic [3:0] am, input logic ap,
                        input logic [3:0] bm, input logic bp, input int lat,
                        input int em, input int ep, input int eo, input bit poke);
    int seen_lat;
    int dones;
    seen_lat = -1;
    dones    = 0;
    @(negedge clk);
    a_mag = am; a_pos = ap; b_mag = bm; b_pos = bp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_mag = ~am; b_mag = ~bm; a_pos = ~ap; b_pos = ~bp;
    chk({tag, "_busy"}, busy, 1);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clk);
      if (poke && c == 2) start = 1'b1;
      if (poke && c == 3) start = 1'b0;
      if (done) begin
        dones++;
        if (seen_lat < 0) begin
          seen_lat = c;
          chk({tag, "_mag"}, sum_mag, em);
          chk({tag, "_pos"}, sum_pos, ep);
          chk({tag, "_ovf"}, overflow, eo);
          chk({tag, "_busy_at_done"}, busy, 0);
        end
      end
    end
    chk({tag, "_lat"}, seen_lat, lat);
    chk({tag, "_ndone"}, dones, 1);
  endtask

  initial begin
    int dones;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mag", sum_mag, 0);
    chk("rst_pos", sum_pos, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("p5p3", 4'd5, 1'b1, 4'd3, 1'b1, 5, 8, 1, 0, 1'b0);
    run_op("p3n5", 4'd3, 1'b1, 4'd5, 1'b0, 9, 2, 0, 0, 1'b0);
    run_op("p9p9", 4'd9, 1'b1, 4'd9, 1'b1, 5, 2, 1, 1, 1'b0);
    run_op("p4n4", 4'd4, 1'b1, 4'd4, 1'b0, 5, 0, 1, 0, 1'b0);
    run_op("n0n0", 4'd0, 1'b0, 4'd0, 1'b0, 5, 0, 1, 0, 1'b0);
    run_op("n7p2", 4'd7, 1'b0, 4'd2, 1'b1, 5, 5, 0, 0, 1'b1);
    run_op("n2p7", 4'd2, 1'b0, 4'd7, 1'b1, 9, 5, 1, 0, 1'b0);
    run_op("nFnF", 4'd15, 1'b0, 4'd15, 1'b0, 5, 14, 0, 1, 1'b0);

    // Abort an ADD with reset in cycle N+3.
    @(negedge clk);
    a_mag = 4'd6; a_pos = 1'b1; b_mag = 4'd1; b_pos = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mag", sum_mag, 0);
    chk("abort_pos", sum_pos, 0);
    chk("abort_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_nodone", dones, 0);
    run_op("after_rst", 4'd6, 1'b1, 4'd1, 1'b1, 5, 7, 1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
